// File: rtl/timer_pkg.sv
// Shared definitions for the microsecond interval timer.
//   - Timer state encoding (enum plus legacy-compatible constants)
//   - Mode encoding sampled together with start
//   - Default width of the duration / remaining / period counters
package timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int unsigned TIMER_CNT_W = 16;

endpackage : timer_pkg

// File: rtl/us_interval_timer.sv
// Programmable microsecond interval timer.
// Counts a software-supplied number of 1 us strobes (tick_us) and emits a
// one-clock done pulse at expiry. One-shot and periodic (auto-reload) modes,
// abort and restart. Priority: rst_n > abort > start > tick_us.
//
// Ports:
//   clk        in   system clock (20 MHz)
//   rst_n      in   asynchronous active-low reset
//   tick_us    in   one-clk strobe, nominally once per microsecond
//   start      in   one-clk request: latch dur_us/mode and (re)start timing
//   mode       in   sampled with start: 0 = one-shot, 1 = periodic
//   dur_us     in   duration in microseconds, sampled with start
//   abort      in   stop timing immediately, no done
//   busy       out  high while timing
//   done       out  one-clk pulse at expiry
//   remaining  out  microseconds left in the current interval (0 only when idle)
//   periods    out  done pulses since the last start, wraps modulo 2^CNT_W
module us_interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = TIMER_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_us,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] dur_us,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] periods
);

    logic [0:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             done_q, done_d;
    logic             dur_zero_s;
    logic             in_run_s;

    assign dur_zero_s = (dur_us == {CNT_W{1'b0}});
    assign in_run_s   = (state_q == ST_RUN);

    // Next-state logic: abort beats start, start beats tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dur_d   = dur_q;
        rem_d   = rem_q;
        per_d   = per_q;
        done_d  = 1'b0;

        if (abort) begin
            // In IDLE this is a no-op since remaining is already zero.
            state_d = ST_IDLE;
            rem_d   = {CNT_W{1'b0}};
        end else if (start) begin
            mode_d = mode;
            dur_d  = dur_us;
            if (dur_zero_s) begin
                // Zero duration expires at once and never enters RUN.
                state_d = ST_IDLE;
                rem_d   = {CNT_W{1'b0}};
                per_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                rem_d   = dur_us;
                per_d   = {CNT_W{1'b0}};
            end
        end else if (tick_us && in_run_s) begin
            if (rem_q > {{(CNT_W-1){1'b0}}, 1'b1}) begin
                rem_d = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                // Expiring tick: remaining is never 0 in RUN, so this is rem==1.
                done_d = 1'b1;
                per_d  = per_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (mode_q == MODE_PERIODIC) begin
                    rem_d = dur_q;
                end else begin
                    state_d = ST_IDLE;
                    rem_d   = {CNT_W{1'b0}};
                end
            end
        end else begin
            done_d = 1'b0;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ONESHOT;
            dur_q   <= {CNT_W{1'b0}};
            rem_q   <= {CNT_W{1'b0}};
            per_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dur_q   <= dur_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    // busy is the state flop itself (RUN encodes as 1).
    assign busy      = in_run_s;
    assign done      = done_q;
    assign remaining = rem_q;
    assign periods   = per_q;

endmodule : us_interval_timer
